mul_acc_seq: RTL and testbench

Operand sequencer and accumulator that sits directly in front of and behind the sequential multiplier `mul`. It accepts operand pairs over a valid/ready handshake and issues each pair to `mul` with a one-cycle start pulse. On `fin` it captures the product and adds it into a running sum. When a term flagged `in_last` completes, it emits the dot-product result.

---
 rtl/mul_acc_seq_pkg.sv | 16 +
 rtl/mul_acc_seq_wdog.sv | 30 +++
 rtl/mul_acc_seq.sv | 156 +++++++++++++++
 tb/tb_mul_acc_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_seq_pkg.sv
// Shared definitions for the mul_acc_seq operand sequencer / accumulator:
// FSM encodings, state width and the accumulator width macro.
`ifndef MUL_ACC_ACCW
`define MUL_ACC_ACCW(wa, wb, wc) ((wa) + (wb) + 1 + (wc))
`endif

package mul_acc_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mul_acc_seq_wdog.sv
// Watchdog for the multiplier wait phase of mul_acc_seq; only instantiated
// when MUL_TIMEOUT_EN is defined.
module mul_acc_wdog #(
    parameter int wT = 6
) (
    input  logic ck,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [wT-1:0] count_r;

    // Count wait cycles; expiry fires on the edge where the count reaches all-ones
    always_ff @(posedge ck) begin
        if (rst) begin
            count_r <= {wT{1'b0}};
        end else if (clr) begin
            count_r <= {wT{1'b0}};
        end else if (en && (count_r != {wT{1'b1}})) begin
            count_r <= count_r + {{(wT-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en & (count_r == {{(wT-1){1'b1}}, 1'b0});

endmodule

// File: rtl/mul_acc_seq.sv
// Operand sequencer and dot-product accumulator around an external sequential
// multiplier. Optional watchdog on the multiplier wait: define MUL_TIMEOUT_EN.
module mul_acc_seq
    import mul_acc_seq_pkg::*;
#(
    parameter int wA = 8,
    parameter int wB = 8,
    parameter int wC = 4,
    parameter int wN = 4,
    parameter int wT = 6
) (
    input  logic                                ck,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [wA-1:0]                       in_a,
    input  logic [wB-1:0]                       in_b,
    input  logic                                in_last,
    output logic [wA-1:0]                       mul_a,
    output logic [wB-1:0]                       mul_b,
    output logic                                mul_start,
    input  logic                                mul_fin,
    input  logic [wA+wB:0]                      mul_o,
    output logic [`MUL_ACC_ACCW(wA,wB,wC)-1:0]  acc,
    output logic                                acc_valid,
    output logic                                acc_ovf,
    output logic [wN-1:0]                       cnt
`ifdef MUL_TIMEOUT_EN
    ,
    output logic                                tmo_err
`endif
);

    localparam int wS = `MUL_ACC_ACCW(wA, wB, wC);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nxt_s;
    logic               last_r;
    logic               group_end_r;
    logic               accept_s;
    logic               fin_s;
    logic               timeout_s;
    logic [wS:0]        sum_s;

    assign accept_s = in_valid & in_ready;
    assign fin_s    = (state_r == ST_WAIT) & mul_fin;
    assign sum_s    = {1'b0, acc} + {{(wC+1){1'b0}}, mul_o};

`ifdef MUL_TIMEOUT_EN
    logic wdog_exp_s;

    mul_acc_wdog #(
        .wT (wT)
    ) u_wdog (
        .ck      (ck),
        .rst     (rst),
        .clr     (state_r == ST_ISSUE),
        .en      (state_r == ST_WAIT),
        .expired (wdog_exp_s)
    );

    assign timeout_s = wdog_exp_s & ~mul_fin;
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decode; a product arriving on the expiry edge still wins
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (mul_fin) begin
                    state_nxt_s = last_r ? ST_DONE : ST_IDLE;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control flops: state plus handshake / pulse outputs decoded from next state
    always_ff @(posedge ck) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready    <= 1'b1;
            mul_start   <= 1'b0;
            acc_valid   <= 1'b0;
            group_end_r <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            in_ready  <= (state_nxt_s == ST_IDLE);
            mul_start <= (state_nxt_s == ST_ISSUE);
            acc_valid <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                group_end_r <= 1'b0;
            end else if ((state_nxt_s == ST_DONE) || timeout_s) begin
                group_end_r <= 1'b1;
            end else begin
                group_end_r <= group_end_r;
            end
        end
    end

    // Operand capture and accumulation; first accept of a new group clears the sum
    always_ff @(posedge ck) begin
        if (rst) begin
            mul_a   <= {wA{1'b0}};
            mul_b   <= {wB{1'b0}};
            last_r  <= 1'b0;
            acc     <= {wS{1'b0}};
            acc_ovf <= 1'b0;
            cnt     <= {wN{1'b0}};
        end else if (accept_s) begin
            mul_a  <= in_a;
            mul_b  <= in_b;
            last_r <= in_last;
            if (group_end_r) begin
                acc     <= {wS{1'b0}};
                acc_ovf <= 1'b0;
                cnt     <= {wN{1'b0}};
            end
        end else if (fin_s) begin
            acc     <= sum_s[wS-1:0];
            acc_ovf <= acc_ovf | sum_s[wS];
            if (cnt != {wN{1'b1}}) begin
                cnt <= cnt + {{(wN-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge ck) begin
        if (rst) begin
            tmo_err <= 1'b0;
        end else if (timeout_s) begin
            tmo_err <= 1'b1;
        end else begin
            tmo_err <= tmo_err;
        end
    end
`endif

endmodule

// File: tb/tb_mul_acc_seq.sv
// Self-checking bench for mul_acc_seq (default build): vector table, overflow,
// back-pressure, reset-in-WAIT and randomized groups against an arithmetic model.
module tb_mul_acc_seq;

    logic        ck = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_start;
    logic        mul_fin;
    logic [16:0] mul_o;
    logic [20:0] acc;
    logic        acc_valid;
    logic        acc_ovf;
    logic [3:0]  cnt;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int valids = 0;
    int exp_starts = 0;
    int exp_valids = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         last;
        int         lat;
        int         eacc;
        int         ecnt;
    } vec_t;

    vec_t vt[7];

    mul_acc_seq dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_fin   (mul_fin),
        .mul_o     (mul_o),
        .acc       (acc),
        .acc_valid (acc_valid),
        .acc_ovf   (acc_ovf),
        .cnt       (cnt)
    );

    always #5 ck = ~ck;

    // Pulse counters sampled away from the active edge
    always @(negedge ck) begin
        if (mul_start) starts++;
        if (acc_valid) valids++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1; in_valid = 1'b0; mul_fin = 1'b0; in_last = 1'b0;
        @(negedge ck);
        rst = 1'b0;
    endtask

    // Offer one pair, act as the multiplier with latency lat, return at the negedge after fin
    task automatic send_term(input logic [7:0] a, input logic [7:0] b, input bit last,
                             input int lat, input int gap);
        int w;
        repeat (gap) @(negedge ck);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge ck);
            w++;
        end
        if (w >= 50) check("accept_wait", 32'(in_ready), 32'd1);
        @(negedge ck);
        in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'b0;
        exp_starts++;
        check("mul_start", 32'(mul_start), 32'd1);
        check("mul_a", 32'(mul_a), 32'(a));
        check("mul_b", 32'(mul_b), 32'(b));
        check("busy_ready", 32'(in_ready), 32'd0);
        repeat (lat) @(negedge ck);
        check("mul_a_hold", 32'(mul_a), 32'(a));
        mul_fin = 1'b1; mul_o = 17'(a) * 17'(b);
        @(negedge ck);
        mul_fin = 1'b0; mul_o = 17'($urandom);
    endtask

    task automatic check_after(input string tag, input int eacc, input int ecnt,
                               input int eovf, input bit last);
        check({tag, "_acc"}, 32'(acc), eacc);
        check({tag, "_cnt"}, 32'(cnt), ecnt);
        check({tag, "_ovf"}, 32'(acc_ovf), eovf);
        check({tag, "_valid"}, 32'(acc_valid), 32'(last));
        check({tag, "_ready"}, 32'(in_ready), 32'(!last));
        if (last) begin
            exp_valids++;
            @(negedge ck);
            check({tag, "_valid_off"}, 32'(acc_valid), 32'd0);
            check({tag, "_acc_hold"}, 32'(acc), eacc);
            check({tag, "_nvalid"}, 32'(valids), 32'(exp_valids));
        end
    endtask

    initial begin
        longint sum;
        int     n;
        int     len;
        logic [7:0] ra;
        logic [7:0] rb;

        vt[0] = '{8'd3,   8'd5,   1'b1, 2, 15,     1};
        vt[1] = '{8'd255, 8'd255, 1'b0, 3, 65025,  1};
        vt[2] = '{8'd255, 8'd255, 1'b0, 1, 130050, 2};
        vt[3] = '{8'd255, 8'd255, 1'b1, 4, 195075, 3};
        vt[4] = '{8'd7,   8'd9,   1'b1, 1, 63,     1};
        vt[5] = '{8'd0,   8'd200, 1'b0, 2, 0,      1};
        vt[6] = '{8'd128, 8'd2,   1'b1, 5, 256,    2};

        rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0;
        mul_fin = 1'b0; mul_o = 17'd0;
        do_reset();
        starts = 0; valids = 0;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_ovf", 32'(acc_ovf), 32'd0);
        check("rst_start", 32'(mul_start), 32'd0);
        check("rst_valid", 32'(acc_valid), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);

        for (int i = 0; i < 7; i++) begin
            send_term(vt[i].a, vt[i].b, vt[i].last, vt[i].lat, 0);
            check_after($sformatf("vec%0d", i), vt[i].eacc, vt[i].ecnt, 0, vt[i].last);
            check("vec_starts", 32'(starts), 32'(exp_starts));
        end

        // 33 full-scale terms: wraps the 21-bit sum on the 33rd and saturates cnt
        for (int i = 1; i <= 33; i++) begin
            send_term(8'd255, 8'd255, (i == 33), 1, 0);
            if (i == 32) check_after("ovf32", 2080800, 15, 0, 1'b0);
        end
        check_after("ovf33", 48673, 15, 1, 1'b1);

        // Back-pressure: next pair held on in_valid during WAIT
        in_valid = 1'b1; in_a = 8'd10; in_b = 8'd20; in_last = 1'b0;
        @(negedge ck);
        in_a = 8'd99; in_b = 8'd77; in_last = 1'b1;
        exp_starts++;
        check("bp_start1", 32'(mul_start), 32'd1);
        repeat (3) begin
            @(negedge ck);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_mul_a", 32'(mul_a), 32'd10);
            check("bp_mul_b", 32'(mul_b), 32'd20);
        end
        mul_fin = 1'b1; mul_o = 17'd200;
        @(negedge ck);
        mul_fin = 1'b0;
        check("bp_acc1", 32'(acc), 32'd200);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        @(negedge ck);
        in_valid = 1'b0;
        exp_starts++;
        check("bp_start2", 32'(mul_start), 32'd1);
        check("bp_mul_a2", 32'(mul_a), 32'd99);
        check("bp_mul_b2", 32'(mul_b), 32'd77);
        @(negedge ck);
        mul_fin = 1'b1; mul_o = 17'd7623;
        @(negedge ck);
        mul_fin = 1'b0;
        check_after("bp", 7823, 2, 0, 1'b1);

        // Reset during WAIT, then a stale fin
        in_valid = 1'b1; in_a = 8'd11; in_b = 8'd13; in_last = 1'b1;
        @(negedge ck);
        in_valid = 1'b0;
        exp_starts++;
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0; mul_fin = 1'b1; mul_o = 17'd143;
        @(negedge ck);
        mul_fin = 1'b0;
        check("rw_acc", 32'(acc), 32'd0);
        check("rw_cnt", 32'(cnt), 32'd0);
        check("rw_ovf", 32'(acc_ovf), 32'd0);
        check("rw_ready", 32'(in_ready), 32'd1);
        check("rw_mul_a", 32'(mul_a), 32'd0);
        check("rw_start", 32'(mul_start), 32'd0);
        @(negedge ck);
        check("rw_valid", 32'(acc_valid), 32'd0);
        check("rw_acc_hold", 32'(acc), 32'd0);
        check("rw_nvalid", 32'(valids), 32'(exp_valids));

        // Randomized groups against an arithmetic model of the sum
        for (int g = 0; g < 25; g++) begin
            len = $urandom_range(1, 5);
            sum = 0;
            n = 0;
            for (int k = 0; k < len; k++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                sum += longint'(ra) * longint'(rb);
                n++;
                send_term(ra, rb, (k == len - 1), $urandom_range(1, 4), $urandom_range(0, 2));
                check_after("rnd", int'(sum % 64'd2097152), (n > 15) ? 15 : n,
                            (sum >= 64'd2097152) ? 1 : 0, (k == len - 1));
            end
        end

        @(negedge ck);
        check("total_starts", 32'(starts), 32'(exp_starts));
        check("total_valids", 32'(valids), 32'(exp_valids));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
